// File: rtl/evaluate_killer_multi_pkg.sv
// ----------------------------------------------------------------------------
// evaluate_killer_multi_pkg
// Shared constants and types for the killer-move evaluation term.
//   BOARD_WIDTH       width of a packed board position
//   MAX_DEPTH         deepest ply the search can reach
//   KILLER_SLOTS_MAX  upper bound on killer slots per ply (slot index is 3 bits)
//   upd_state_t       update FSM encoding (IDLE / SEARCH / WRITE)
// ----------------------------------------------------------------------------
package evaluate_killer_multi_pkg;

    localparam int BOARD_WIDTH      = 64;
    localparam int MAX_DEPTH        = 16;
    localparam int KILLER_SLOTS_MAX = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_WRITE  = 2'd2
    } upd_state_t;

endpackage

// File: rtl/evaluate_killer_multi_row_match.sv
// ----------------------------------------------------------------------------
// killer_row_match
// Combinational search of one killer row for a board.
//   i_row    KILLERS packed boards, slot k at [k*BOARD_WIDTH +: BOARD_WIDTH]
//   i_valid  per-slot valid bits
//   i_board  board to look for
//   o_hit    some valid slot holds i_board
//   o_idx    lowest matching slot index (0 when no hit)
// ----------------------------------------------------------------------------
module killer_row_match
    import evaluate_killer_multi_pkg::*;
#(
    parameter int KILLERS = 2
) (
    input  logic [KILLERS*BOARD_WIDTH-1:0] i_row,
    input  logic [KILLERS-1:0]             i_valid,
    input  logic [BOARD_WIDTH-1:0]         i_board,
    output logic                           o_hit,
    output logic [2:0]                     o_idx
);

    // Scan from the top slot down so the lowest match is the last assignment.
    always_comb begin
        o_hit = 1'b0;
        o_idx = 3'd0;
        for (int k = KILLERS - 1; k >= 0; k--) begin
            if (i_valid[k] && (i_row[k*BOARD_WIDTH +: BOARD_WIDTH] == i_board)) begin
                o_hit = 1'b1;
                o_idx = 3'(k);
            end
        end
    end

endmodule

// File: rtl/evaluate_killer_multi.sv
// ----------------------------------------------------------------------------
// evaluate_killer_multi
// Killer-move evaluation term: per-ply table of KILLERS boards kept in
// move-to-front order, returning the sign-adjusted bonus of the lowest
// matching slot with a fixed 3-cycle latency.
//   clk, reset            clock, synchronous active-low reset
//   board_valid/board     t0 evaluation request and position
//   white_to_move         negate the bonus when set
//   eval_ply              ply of the evaluation request
//   killer_ply/board      update operands, latched on the update edge
//   killer_update         rising edge starts an update
//   killer_clear          rising edge invalidates every slot of every ply
//   killer_bonus          per-slot signed bonus vector
//   update_busy           update in flight (SEARCH or WRITE)
//   eval_mg_t3/eg_t3      signed result, identical values
//   eval_hit_t3/slot_t3   hit flag and matching slot
//   eval_valid_t3         board_valid delayed by 3 cycles
//   dbg_state             update FSM state
// Handshake: an update is accepted only when update_busy is low; the driver
// raises killer_update, drops it, and waits for update_busy to fall.
// ----------------------------------------------------------------------------
module evaluate_killer_multi
    import evaluate_killer_multi_pkg::*;
#(
    parameter int EVAL_WIDTH     = 16,
    parameter int MAX_DEPTH_LOG2 = 4,
    parameter int KILLERS        = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          board_valid,
    input  logic [BOARD_WIDTH-1:0]        board,
    input  logic                          white_to_move,
    input  logic [MAX_DEPTH_LOG2-1:0]     eval_ply,
    input  logic [MAX_DEPTH_LOG2-1:0]     killer_ply,
    input  logic [BOARD_WIDTH-1:0]        killer_board,
    input  logic                          killer_update,
    input  logic                          killer_clear,
    input  logic [KILLERS*EVAL_WIDTH-1:0] killer_bonus,
    output logic                          update_busy,
    output logic [EVAL_WIDTH-1:0]         eval_mg_t3,
    output logic [EVAL_WIDTH-1:0]         eval_eg_t3,
    output logic                          eval_hit_t3,
    output logic [2:0]                    eval_slot_t3,
    output logic                          eval_valid_t3,
    output logic [1:0]                    dbg_state
);

    localparam int DEPTH = 1 << MAX_DEPTH_LOG2;
    localparam int RW    = KILLERS * BOARD_WIDTH;
    localparam int BW    = KILLERS * EVAL_WIDTH;

    logic [RW-1:0]      r_table [DEPTH];
    logic [KILLERS-1:0] r_valid [DEPTH];

    logic                      r_upd_d, r_clr_d;
    upd_state_t                r_state;
    logic [MAX_DEPTH_LOG2-1:0] r_upd_ply;
    logic [BOARD_WIDTH-1:0]    r_upd_board;
    logic                      r_match;
    logic [2:0]                r_match_idx;

    logic w_upd_edge, w_clr_edge;
    assign w_upd_edge = killer_update & ~r_upd_d;
    assign w_clr_edge = killer_clear  & ~r_clr_d;

    assign update_busy = (r_state != ST_IDLE);
    assign dbg_state   = r_state;

    // ---------------- update path ----------------
    logic [RW-1:0] w_upd_row, w_new_row;
    logic          w_s_hit;
    logic [2:0]    w_s_idx;

    assign w_upd_row = r_table[r_upd_ply];

    killer_row_match #(.KILLERS(KILLERS)) u_search (
        .i_row   (w_upd_row),
        .i_valid (r_valid[r_upd_ply]),
        .i_board (r_upd_board),
        .o_hit   (w_s_hit),
        .o_idx   (w_s_idx)
    );

    // Move-to-front: on a hit at m only slots 0..m-1 move down; on a miss
    // every slot moves down and the last one falls off.
    always_comb begin
        w_new_row = w_upd_row;
        w_new_row[0 +: BOARD_WIDTH] = r_upd_board;
        for (int k = 1; k < KILLERS; k++) begin
            if (!r_match || (k <= int'(r_match_idx))) begin
                w_new_row[k*BOARD_WIDTH +: BOARD_WIDTH] = w_upd_row[(k-1)*BOARD_WIDTH +: BOARD_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_upd_d     <= 1'b0;
            r_clr_d     <= 1'b0;
            r_state     <= ST_IDLE;
            r_upd_ply   <= '0;
            r_upd_board <= '0;
            r_match     <= 1'b0;
            r_match_idx <= 3'd0;
            for (int p = 0; p < DEPTH; p++) r_valid[p] <= '0;
        end else begin
            r_upd_d <= killer_update;
            r_clr_d <= killer_clear;
            if (w_clr_edge) begin
                // Clear wins over any update in progress or arriving now.
                r_state <= ST_IDLE;
                for (int p = 0; p < DEPTH; p++) r_valid[p] <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_upd_edge) begin
                            r_upd_ply   <= killer_ply;
                            r_upd_board <= killer_board;
                            r_state     <= ST_SEARCH;
                        end
                    end
                    ST_SEARCH: begin
                        r_match     <= w_s_hit;
                        r_match_idx <= w_s_idx;
                        r_state     <= ST_WRITE;
                    end
                    ST_WRITE: begin
                        if (!r_match) begin
                            r_valid[r_upd_ply] <= {r_valid[r_upd_ply][KILLERS-2:0], 1'b1};
                        end
                        r_state <= ST_IDLE;
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    // Table data is not reset; a write is suppressed by reset or clear.
    always_ff @(posedge clk) begin
        if (reset && !w_clr_edge && (r_state == ST_WRITE)) begin
            r_table[r_upd_ply] <= w_new_row;
        end
    end

    // ---------------- evaluation pipeline ----------------
    logic [BW-1:0] w_adj_bonus;
    always_comb begin
        w_adj_bonus = '0;
        for (int k = 0; k < KILLERS; k++) begin
            w_adj_bonus[k*EVAL_WIDTH +: EVAL_WIDTH] = white_to_move
                ? -killer_bonus[k*EVAL_WIDTH +: EVAL_WIDTH]
                :  killer_bonus[k*EVAL_WIDTH +: EVAL_WIDTH];
        end
    end

    logic                   r1_valid;
    logic [RW-1:0]          r1_row;
    logic [KILLERS-1:0]     r1_vbits;
    logic [BOARD_WIDTH-1:0] r1_board;
    logic [BW-1:0]          r1_bonus;
    logic                   r2_valid, r2_hit;
    logic [2:0]             r2_idx;
    logic [EVAL_WIDTH-1:0]  r2_bonus;
    logic [EVAL_WIDTH-1:0]  r_eval_t3;
    logic                   r_hit_t3, r_valid_t3;
    logic [2:0]             r_slot_t3;

    logic                  w_e_hit;
    logic [2:0]            w_e_idx;
    logic [EVAL_WIDTH-1:0] w_sel_bonus;

    killer_row_match #(.KILLERS(KILLERS)) u_eval (
        .i_row   (r1_row),
        .i_valid (r1_vbits),
        .i_board (r1_board),
        .o_hit   (w_e_hit),
        .o_idx   (w_e_idx)
    );

    always_comb begin
        w_sel_bonus = '0;
        for (int k = 0; k < KILLERS; k++) begin
            if (3'(k) == w_e_idx) w_sel_bonus = r1_bonus[k*EVAL_WIDTH +: EVAL_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r1_valid   <= 1'b0;
            r1_row     <= '0;
            r1_vbits   <= '0;
            r1_board   <= '0;
            r1_bonus   <= '0;
            r2_valid   <= 1'b0;
            r2_hit     <= 1'b0;
            r2_idx     <= 3'd0;
            r2_bonus   <= '0;
            r_valid_t3 <= 1'b0;
            r_eval_t3  <= '0;
            r_hit_t3   <= 1'b0;
            r_slot_t3  <= 3'd0;
        end else begin
            r1_valid   <= board_valid;
            r1_row     <= r_table[eval_ply];
            r1_vbits   <= r_valid[eval_ply];
            r1_board   <= board;
            r1_bonus   <= w_adj_bonus;
            r2_valid   <= r1_valid;
            r2_hit     <= w_e_hit;
            r2_idx     <= w_e_idx;
            r2_bonus   <= w_e_hit ? w_sel_bonus : '0;
            r_valid_t3 <= r2_valid;
            if (r2_valid) begin
                r_eval_t3 <= r2_bonus;
                r_hit_t3  <= r2_hit;
                r_slot_t3 <= r2_idx;
            end
        end
    end

    assign eval_mg_t3    = r_eval_t3;
    assign eval_eg_t3    = r_eval_t3;
    assign eval_hit_t3   = r_hit_t3;
    assign eval_slot_t3  = r_slot_t3;
    assign eval_valid_t3 = r_valid_t3;

endmodule

// File: tb/tb_evaluate_killer_multi.sv
module tb_evaluate_killer_multi;
  import evaluate_killer_multi_pkg::*;

  localparam int EW = 16;
  localparam int DL = 4;
  localparam int KN = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   board_valid;
  logic [BOARD_WIDTH-1:0] board;
  logic                   white_to_move;
  logic [DL-1:0]          eval_ply;
  logic [DL-1:0]          killer_ply;
  logic [BOARD_WIDTH-1:0] killer_board;
  logic                   killer_update;
  logic                   killer_clear;
  logic [KN*EW-1:0]       killer_bonus;
  logic                   update_busy;
  logic [EW-1:0]          eval_mg_t3, eval_eg_t3;
  logic                   eval_hit_t3;
  logic [2:0]             eval_slot_t3;
  logic                   eval_valid_t3;
  logic [1:0]             dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [KN*EW-1:0] BV2 = {16'd0, 16'd0, 16'd10, 16'd20};
  localparam logic [KN*EW-1:0] BV4 = {16'd400, 16'd300, 16'd200, 16'd100};

  localparam logic [BOARD_WIDTH-1:0] B_A = 64'h0000_1111_AAAA_0001;
  localparam logic [BOARD_WIDTH-1:0] B_B = 64'h0000_2222_BBBB_0002;
  localparam logic [BOARD_WIDTH-1:0] B_C = 64'h0000_3333_CCCC_0003;
  localparam logic [BOARD_WIDTH-1:0] B_D = 64'h0000_4444_DDDD_0004;
  localparam logic [BOARD_WIDTH-1:0] B_E = 64'h0000_5555_EEEE_0005;
  localparam logic [BOARD_WIDTH-1:0] B_F = 64'hF000_0000_0000_0006;
  localparam logic [BOARD_WIDTH-1:0] B_G = 64'h0F00_0000_0000_0007;
  localparam logic [BOARD_WIDTH-1:0] B_H = 64'h00F0_0000_0000_0008;
  localparam logic [BOARD_WIDTH-1:0] B_J = 64'h000F_0000_0000_0009;
  localparam logic [BOARD_WIDTH-1:0] B_K = 64'h1234_5678_9ABC_DEF0;

  evaluate_killer_multi #(.EVAL_WIDTH(EW), .MAX_DEPTH_LOG2(DL), .KILLERS(KN)) dut (
    .clk           (clk),
    .reset         (reset),
    .board_valid   (board_valid),
    .board         (board),
    .white_to_move (white_to_move),
    .eval_ply      (eval_ply),
    .killer_ply    (killer_ply),
    .killer_board  (killer_board),
    .killer_update (killer_update),
    .killer_clear  (killer_clear),
    .killer_bonus  (killer_bonus),
    .update_busy   (update_busy),
    .eval_mg_t3    (eval_mg_t3),
    .eval_eg_t3    (eval_eg_t3),
    .eval_hit_t3   (eval_hit_t3),
    .eval_slot_t3  (eval_slot_t3),
    .eval_valid_t3 (eval_valid_t3),
    .dbg_state     (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic wait_idle(input string tag);
    int n = 0;
    while (update_busy && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_busy_bound"}, 64'(update_busy), 64'd0);
  endtask

  task automatic do_update(input logic [DL-1:0] ply, input logic [BOARD_WIDTH-1:0] brd);
    killer_ply    = ply;
    killer_board  = brd;
    killer_update = 1'b1;
    tick();
    killer_update = 1'b0;
    wait_idle("upd");
  endtask

  task automatic eval_chk(input string tag, input logic [DL-1:0] ply,
                          input logic [BOARD_WIDTH-1:0] brd, input logic wtm,
                          input logic [KN*EW-1:0] bonus, input logic [EW-1:0] exp_val,
                          input logic exp_hit, input logic [2:0] exp_slot);
    board_valid   = 1'b1;
    board         = brd;
    eval_ply      = ply;
    white_to_move = wtm;
    killer_bonus  = bonus;
    tick();
    board_valid = 1'b0;
    tick();
    tick();
    check({tag, "_valid"}, 64'(eval_valid_t3), 64'd1);
    check({tag, "_mg"},    64'(eval_mg_t3),    64'(exp_val));
    check({tag, "_eg"},    64'(eval_eg_t3),    64'(exp_val));
    check({tag, "_hit"},   64'(eval_hit_t3),   64'(exp_hit));
    check({tag, "_slot"},  64'(eval_slot_t3),  64'(exp_slot));
  endtask

  initial begin
    reset = 1'b0; board_valid = 1'b0; board = '0; white_to_move = 1'b0;
    eval_ply = '0; killer_ply = '0; killer_board = '0;
    killer_update = 1'b0; killer_clear = 1'b0; killer_bonus = '0;
    tick(); tick();
    check("rst_valid", 64'(eval_valid_t3), 64'd0);
    check("rst_mg",    64'(eval_mg_t3),    64'd0);
    check("rst_hit",   64'(eval_hit_t3),   64'd0);
    check("rst_busy",  64'(update_busy),   64'd0);
    check("rst_state", 64'(dbg_state),     64'd0);
    reset = 1'b1;
    tick();

    // empty table misses
    eval_chk("empty_p3", 4'd3, B_K, 1'b0, BV2, 16'd0, 1'b0, 3'd0);

    // two updates at ply 2, black and white to move
    do_update(4'd2, B_A);
    do_update(4'd2, B_B);
    eval_chk("p2_B_blk", 4'd2, B_B, 1'b0, BV2, 16'd20, 1'b1, 3'd0);
    tick();
    check("hold_valid", 64'(eval_valid_t3), 64'd0);
    check("hold_mg",    64'(eval_mg_t3),    64'd20);
    eval_chk("p2_A_blk", 4'd2, B_A, 1'b0, BV2, 16'd10, 1'b1, 3'd1);
    eval_chk("p2_B_wht", 4'd2, B_B, 1'b1, BV2, 16'hFFEC, 1'b1, 3'd0);
    eval_chk("p2_A_wht", 4'd2, B_A, 1'b1, BV2, 16'hFFF6, 1'b1, 3'd1);

    // four slots: fill past capacity, then move-to-front of a resident entry
    do_update(4'd6, B_A);
    do_update(4'd6, B_B);
    do_update(4'd6, B_C);
    do_update(4'd6, B_D);
    do_update(4'd6, B_E);
    eval_chk("p6_E", 4'd6, B_E, 1'b0, BV4, 16'd100, 1'b1, 3'd0);
    eval_chk("p6_D", 4'd6, B_D, 1'b0, BV4, 16'd200, 1'b1, 3'd1);
    eval_chk("p6_C", 4'd6, B_C, 1'b0, BV4, 16'd300, 1'b1, 3'd2);
    eval_chk("p6_B", 4'd6, B_B, 1'b0, BV4, 16'd400, 1'b1, 3'd3);
    eval_chk("p6_A_evicted", 4'd6, B_A, 1'b0, BV4, 16'd0, 1'b0, 3'd0);
    do_update(4'd6, B_C);
    eval_chk("mtf_C", 4'd6, B_C, 1'b0, BV4, 16'd100, 1'b1, 3'd0);
    eval_chk("mtf_E", 4'd6, B_E, 1'b0, BV4, 16'd200, 1'b1, 3'd1);
    eval_chk("mtf_D", 4'd6, B_D, 1'b0, BV4, 16'd300, 1'b1, 3'd2);
    eval_chk("mtf_B", 4'd6, B_B, 1'b0, BV4, 16'd400, 1'b1, 3'd3);

    // second update edge while busy is ignored
    killer_ply = 4'd5; killer_board = B_F; killer_update = 1'b1;
    tick();
    check("busy_search", 64'(update_busy), 64'd1);
    killer_update = 1'b0;
    tick();
    check("busy_write", 64'(update_busy), 64'd1);
    killer_board = B_G; killer_update = 1'b1;
    tick();
    killer_update = 1'b0;
    tick();
    check("ignored_idle", 64'(update_busy), 64'd0);
    eval_chk("p5_F", 4'd5, B_F, 1'b0, BV4, 16'd100, 1'b1, 3'd0);
    eval_chk("p5_G_ignored", 4'd5, B_G, 1'b0, BV4, 16'd0, 1'b0, 3'd0);
    eval_chk("p4_untouched", 4'd4, B_F, 1'b0, BV4, 16'd0, 1'b0, 3'd0);

    // clear coincident with an update edge
    killer_ply = 4'd7; killer_board = B_H; killer_update = 1'b1; killer_clear = 1'b1;
    tick();
    check("clr_coinc_busy", 64'(update_busy), 64'd0);
    killer_update = 1'b0; killer_clear = 1'b0;
    tick();
    eval_chk("clr_p2_B", 4'd2, B_B, 1'b0, BV2, 16'd0, 1'b0, 3'd0);
    eval_chk("clr_p5_F", 4'd5, B_F, 1'b0, BV2, 16'd0, 1'b0, 3'd0);
    eval_chk("clr_p7_H", 4'd7, B_H, 1'b0, BV2, 16'd0, 1'b0, 3'd0);

    // clear during WRITE
    do_update(4'd2, B_A);
    eval_chk("refill_A", 4'd2, B_A, 1'b0, BV2, 16'd20, 1'b1, 3'd0);
    killer_ply = 4'd7; killer_board = B_H; killer_update = 1'b1;
    tick();
    killer_update = 1'b0;
    tick();
    check("clrw_state_write", 64'(dbg_state), 64'(ST_WRITE));
    killer_clear = 1'b1;
    tick();
    check("clrw_busy", 64'(update_busy), 64'd0);
    killer_clear = 1'b0;
    tick();
    eval_chk("clrw_p2_A", 4'd2, B_A, 1'b0, BV2, 16'd0, 1'b0, 3'd0);
    eval_chk("clrw_p7_H", 4'd7, B_H, 1'b0, BV2, 16'd0, 1'b0, 3'd0);

    // reset mid-update during a streaming burst
    do_update(4'd3, B_K);
    eval_chk("pre_rst_K", 4'd3, B_K, 1'b0, BV4, 16'd100, 1'b1, 3'd0);
    killer_ply = 4'd3; killer_board = B_J; killer_update = 1'b1;
    tick();
    killer_update = 1'b0;
    board_valid = 1'b1; board = B_K; eval_ply = 4'd3; white_to_move = 1'b0; killer_bonus = BV4;
    tick();
    reset = 1'b0;
    tick();
    check("mrst_valid", 64'(eval_valid_t3), 64'd0);
    check("mrst_mg",    64'(eval_mg_t3),    64'd0);
    check("mrst_eg",    64'(eval_eg_t3),    64'd0);
    check("mrst_hit",   64'(eval_hit_t3),   64'd0);
    check("mrst_slot",  64'(eval_slot_t3),  64'd0);
    check("mrst_busy",  64'(update_busy),   64'd0);
    reset = 1'b1;
    tick();
    check("mrst_v1", 64'(eval_valid_t3), 64'd0);
    tick();
    check("mrst_v2", 64'(eval_valid_t3), 64'd0);
    tick();
    check("mrst_v3", 64'(eval_valid_t3), 64'd1);
    check("mrst_K_invalid", 64'(eval_hit_t3), 64'd0);
    check("mrst_K_mg", 64'(eval_mg_t3), 64'd0);
    board_valid = 1'b0;
    tick();
    eval_chk("mrst_J", 4'd3, B_J, 1'b0, BV4, 16'd0, 1'b0, 3'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
